// File: rtl/fcmp_pipe.sv
// Two-stage pipelined single-precision compare/select unit (feq/flt/fle/fmin/fmax)
// with valid/ready issue and response handshakes.
module fcmp_pipe #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_z,
    output logic [TAG_W-1:0] out_tag
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MAG_W  = 31;

    localparam logic [2:0] OP_FEQ  = 3'b000;
    localparam logic [2:0] OP_FLT  = 3'b001;
    localparam logic [2:0] OP_FLE  = 3'b010;
    localparam logic [2:0] OP_FMIN = 3'b011;
    localparam logic [2:0] OP_FMAX = 3'b100;

    logic              s1_valid_q, s1_valid_d;
    logic [2:0]        s1_op_q, s1_op_d;
    logic [DATA_W-1:0] s1_x_q, s1_x_d;
    logic [DATA_W-1:0] s1_y_q, s1_y_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
    logic              s1_mlt_q, s1_mlt_d;
    logic              s1_meq_q, s1_meq_d;

    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_z_q, s2_z_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

    logic              s2_adv;
    logic              s1_load;
    logic              x_neg, y_neg, both_zero, bit_eq;
    logic              lt, eq, gt, signed_zero_pair;
    logic [DATA_W-1:0] z_c;

    // Ordering of the S1 operands, built from the magnitude flags captured at issue
    always_comb begin
        x_neg            = s1_x_q[31];
        y_neg            = s1_y_q[31];
        both_zero        = s1_meq_q & (s1_x_q[MAG_W-1:0] == MAG_W'(0));
        bit_eq           = s1_meq_q & (x_neg == y_neg);
        lt               = (x_neg & ~y_neg & ~both_zero)
                         | (~x_neg & ~y_neg & s1_mlt_q)
                         | (x_neg & y_neg & ~s1_mlt_q & ~s1_meq_q);
        eq               = bit_eq | both_zero;
        gt               = ~lt & ~eq;
        signed_zero_pair = both_zero & (x_neg != y_neg);

        z_c = '0;
        case (s1_op_q)
            OP_FEQ:  z_c = DATA_W'(eq);
            OP_FLT:  z_c = DATA_W'(lt);
            OP_FLE:  z_c = DATA_W'(lt | eq);
            OP_FMIN: z_c = signed_zero_pair ? 32'h8000_0000 : (gt ? s1_y_q : s1_x_q);
            OP_FMAX: z_c = signed_zero_pair ? 32'h0000_0000 : (lt ? s1_y_q : s1_x_q);
            default: z_c = '0;
        endcase
    end

    // Handshake and pipeline advance; flush blocks issue and empties both stages
    always_comb begin
        s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready = ~rst & ~flush & (~s1_valid_q | s2_adv);
        s1_load  = in_valid & in_ready;

        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_tag_d   = s1_tag_q;
        s1_mlt_d   = s1_mlt_q;
        s1_meq_d   = s1_meq_q;
        s2_valid_d = s2_valid_q;
        s2_z_d     = s2_z_q;
        s2_tag_d   = s2_tag_q;

        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_op_d    = in_op;
            s1_x_d     = in_x;
            s1_y_d     = in_y;
            s1_tag_d   = in_tag;
            s1_mlt_d   = in_x[MAG_W-1:0] < in_y[MAG_W-1:0];
            s1_meq_d   = in_x[MAG_W-1:0] == in_y[MAG_W-1:0];
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            s2_valid_d = 1'b1;
            s2_z_d     = z_c;
            s2_tag_d   = s1_tag_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_z_q     <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_tag_q   <= s1_tag_d;
            s1_mlt_q   <= s1_mlt_d;
            s1_meq_q   <= s1_meq_d;
            s2_valid_q <= s2_valid_d;
            s2_z_q     <= s2_z_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_z     = s2_z_q;
    assign out_tag   = s2_tag_q;

endmodule
